// File: rtl/spi_target.sv
// Mode-0 MSB-first SPI target with byte-wide RX/TX FIFOs toward an MMIO host.
// SPI pins are oversampled in the clk domain; clk must run at >= 4x sck.

module spi_target_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic [7:0] i_din,
  input  logic       i_push,
  input  logic       i_pop,
  output logic [7:0] o_dout,
  output logic       o_full,
  output logic       o_avail,
  output logic       o_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_avail;
  logic          w_pop_ok;
  logic          w_push_ok;
  logic [AW:0]   w_count_next;

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign w_pop_ok     = i_pop && (r_count != '0);
  assign w_push_ok    = i_push && ((r_count != FULL_CNT) || w_pop_ok);
  assign w_count_next = r_count + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop_ok};

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_avail  <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == FULL_CNT);
      r_avail <= (w_count_next != '0);
    end
  end

  assign o_dout  = r_avail ? r_mem[r_rd_ptr] : 8'h00;
  assign o_full  = r_full;
  assign o_avail = r_avail;
  assign o_drop  = i_push && !w_push_ok;
endmodule

module spi_target #(
  parameter int         DEPTH = 4,
  parameter logic [7:0] FILL  = 8'hFF
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       spi_sck,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_din,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic [7:0] rx_dout,
  input  logic       rx_rd,
  output logic       rx_data_avail,
  output logic       tx_underrun,
  output logic       rx_overflow,
  output logic       frame_abort,
  input  logic       clr_flags
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  // Pin samplers carry no reset: after a mid-frame reset with CS still low the
  // history matches the pin, so no phantom cs_fall restarts the abandoned frame.
  logic [2:0] r_meta;
  logic [2:0] r_sync;
  logic [1:0] r_hist;

  always_ff @(posedge clk) begin
    r_meta <= {spi_mosi, spi_cs, spi_sck};
    r_sync <= r_meta;
    r_hist <= r_sync[1:0];
  end

  logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise, w_mosi;
  assign w_sck_rise = r_sync[0] & ~r_hist[0];
  assign w_sck_fall = ~r_sync[0] & r_hist[0];
  assign w_cs_rise  = r_sync[1] & ~r_hist[1];
  assign w_cs_fall  = ~r_sync[1] & r_hist[1];
  assign w_mosi     = r_sync[2];

  logic [7:0] w_tx_dout, w_rx_shift_in;
  logic       w_tx_avail, w_tx_pop, w_tx_drop, w_rx_full, w_rx_push, w_rx_drop;

  spi_target_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .Rst(Rst), .i_din(tx_din), .i_push(tx_wr), .i_pop(w_tx_pop),
    .o_dout(w_tx_dout), .o_full(tx_full), .o_avail(w_tx_avail), .o_drop(w_tx_drop)
  );

  spi_target_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .Rst(Rst), .i_din(w_rx_shift_in), .i_push(w_rx_push), .i_pop(rx_rd),
    .o_dout(rx_dout), .o_full(w_rx_full), .o_avail(rx_data_avail), .o_drop(w_rx_drop)
  );

  logic w_unused_ok;
  assign w_unused_ok = w_tx_drop ^ w_rx_full;

  state_t     r_state, w_state_next;
  logic [3:0] r_count, w_count_next;
  logic [7:0] r_tx_shift, w_tx_shift_next;
  logic [7:0] r_rx_shift, w_rx_shift_next;
  logic       r_fill, w_fill_next;
  logic       w_abort, w_underrun_set;
  logic [7:0] w_load_byte;

  assign w_load_byte   = w_tx_avail ? w_tx_dout : FILL;
  assign w_rx_shift_in = {r_rx_shift[6:0], w_mosi};

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_state    <= S_IDLE;
      r_count    <= 4'd0;
      r_tx_shift <= FILL;
      r_rx_shift <= 8'h00;
      r_fill     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_tx_shift <= w_tx_shift_next;
      r_rx_shift <= w_rx_shift_next;
      r_fill     <= w_fill_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_tx_shift_next = r_tx_shift;
    w_rx_shift_next = r_rx_shift;
    w_fill_next     = r_fill;
    w_tx_pop        = 1'b0;
    w_rx_push       = 1'b0;
    w_abort         = 1'b0;
    w_underrun_set  = 1'b0;
    spi_miso        = 1'b1;
    spi_miso_oe     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        spi_miso_oe     = 1'b1;
        spi_miso        = w_load_byte[7];
        w_tx_pop        = w_tx_avail;
        w_tx_shift_next = w_load_byte;
        w_fill_next     = !w_tx_avail;
        w_count_next    = 4'd0;
        w_state_next    = w_cs_rise ? S_IDLE : S_SHIFT;
      end
      S_SHIFT: begin
        spi_miso_oe = 1'b1;
        spi_miso    = r_tx_shift[7];
        if (w_sck_rise && r_count != 4'd8) begin
          w_rx_shift_next = w_rx_shift_in;
          w_count_next    = r_count + 4'd1;
          // FILL only counts as sent once the master actually clocks it out;
          // the look-ahead load after a frame's last byte is not an underrun.
          if (r_count == 4'd0 && r_fill) w_underrun_set = 1'b1;
          if (r_count == 4'd7) w_rx_push = 1'b1;
        end else if (w_sck_fall) begin
          if (r_count == 4'd8) begin
            w_state_next = S_LOAD;
            w_count_next = 4'd0;
          end else if (r_count != 4'd0) begin
            w_tx_shift_next = {r_tx_shift[6:0], 1'b0};
          end
        end
        if (w_cs_rise) begin
          w_state_next = S_IDLE;
          if (w_count_next != 4'd0 && w_count_next != 4'd8) w_abort = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  logic r_tx_underrun, r_rx_overflow, r_frame_abort;

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_tx_underrun <= 1'b0;
      r_rx_overflow <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_tx_underrun <= clr_flags ? 1'b0 : (r_tx_underrun | w_underrun_set);
      r_rx_overflow <= clr_flags ? 1'b0 : (r_rx_overflow | w_rx_drop);
      r_frame_abort <= w_abort;
    end
  end

  assign tx_underrun = r_tx_underrun;
  assign rx_overflow = r_rx_overflow;
  assign frame_abort = r_frame_abort;
endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a bit-banged mode-0 master at sck = clk/8
// plus MMIO-side FIFO traffic, checked with immediate assertions.

module tb_spi_target;
  logic       clk = 1'b0;
  logic       Rst = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_din = 8'h00;
  logic       tx_wr = 1'b0;
  logic       tx_full;
  logic [7:0] rx_dout;
  logic       rx_rd = 1'b0;
  logic       rx_data_avail;
  logic       tx_underrun, rx_overflow, frame_abort;
  logic       clr_flags = 1'b0;

  spi_target #(.DEPTH(4), .FILL(8'hFF)) dut (
    .clk(clk), .Rst(Rst), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .tx_din(tx_din), .tx_wr(tx_wr),
    .tx_full(tx_full), .rx_dout(rx_dout), .rx_rd(rx_rd), .rx_data_avail(rx_data_avail),
    .tx_underrun(tx_underrun), .rx_overflow(rx_overflow), .frame_abort(frame_abort),
    .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int abort_cnt = 0;

  always @(posedge clk) begin
    if (frame_abort === 1'b1) abort_cnt <= abort_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-24s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_din = b;
    tx_wr  = 1'b1;
    @(negedge clk);
    tx_wr  = 1'b0;
  endtask

  task automatic pop_rx(input string tag, input logic [7:0] exp);
    chk({tag, "_avail"}, rx_data_avail, 1);
    chk(tag, rx_dout, exp);
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  task automatic cs_start();
    spi_cs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clk);
    spi_cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Shifts nbits of mo MSB first; samples MISO just before each rising sck.
  // rd_last raises rx_rd for the single cycle in which the last bit's byte is pushed.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit rd_last,
                      output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = mo[i];
      repeat (4) @(negedge clk);
      mi[i] = spi_miso;
      spi_sck = 1'b1;
      if (rd_last && i == 0) begin
        repeat (2) @(negedge clk);
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      spi_sck = 1'b0;
    end
  endtask

  logic [7:0] mi;
  int         abort_base;

  initial begin
    repeat (3) @(negedge clk);
    Rst = 1'b0;
    chk("rst_miso", spi_miso, 1);
    chk("rst_oe", spi_miso_oe, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_avail", rx_data_avail, 0);
    chk("rst_rx_dout", rx_dout, 8'h00);
    chk("rst_underrun", tx_underrun, 0);
    chk("rst_overflow", rx_overflow, 0);
    chk("rst_abort", frame_abort, 0);

    // Two-byte frame with queued TX data
    push_tx(8'hA5);
    push_tx(8'h3C);
    cs_start();
    chk("frame_oe", spi_miso_oe, 1);
    xfer(8'h12, 8, 1'b0, mi);
    chk("t1_miso0", mi, 8'hA5);
    xfer(8'h34, 8, 1'b0, mi);
    chk("t1_miso1", mi, 8'h3C);
    cs_end();
    chk("t1_oe_idle", spi_miso_oe, 0);
    chk("t1_underrun", tx_underrun, 0);
    chk("t1_abort_cnt", abort_cnt, 0);
    pop_rx("t1_rx0", 8'h12);
    pop_rx("t1_rx1", 8'h34);
    chk("t1_rx_empty", rx_data_avail, 0);

    // Empty TX FIFO sends FILL
    cs_start();
    xfer(8'h55, 8, 1'b0, mi);
    cs_end();
    chk("t2_miso_fill", mi, 8'hFF);
    chk("t2_underrun", tx_underrun, 1);
    pulse_clr();
    chk("t2_underrun_clr", tx_underrun, 0);
    pop_rx("t2_rx", 8'h55);

    // RX overflow: DEPTH+1 bytes with no reads
    cs_start();
    for (int b = 1; b <= 5; b++) xfer(8'(b), 8, 1'b0, mi);
    cs_end();
    chk("t3_overflow", rx_overflow, 1);
    for (int b = 1; b <= 4; b++) pop_rx("t3_rx", 8'(b));
    chk("t3_rx_empty", rx_data_avail, 0);
    pulse_clr();
    chk("t3_flags_clr", {tx_underrun, rx_overflow}, 0);

    // Same, but rx_rd coincides with the fifth push
    cs_start();
    for (int b = 1; b <= 5; b++) xfer(8'(b), 8, b == 5, mi);
    cs_end();
    chk("t3b_overflow", rx_overflow, 0);
    for (int b = 2; b <= 5; b++) pop_rx("t3b_rx", 8'(b));
    chk("t3b_rx_empty", rx_data_avail, 0);
    pulse_clr();

    // CS rises after three bits
    abort_base = abort_cnt;
    cs_start();
    xfer(8'hF0, 3, 1'b0, mi);
    cs_end();
    chk("t4_abort_once", abort_cnt - abort_base, 1);
    chk("t4_rx_unchanged", rx_data_avail, 0);
    pulse_clr();
    push_tx(8'h81);
    cs_start();
    xfer(8'h00, 8, 1'b0, mi);
    cs_end();
    chk("t4_miso_81", mi, 8'h81);
    chk("t4_underrun", tx_underrun, 0);
    pop_rx("t4_rx", 8'h00);

    // TX full, ignored write, write during LOAD
    push_tx(8'h11);
    push_tx(8'h22);
    push_tx(8'h33);
    push_tx(8'h44);
    chk("t5_full", tx_full, 1);
    push_tx(8'h99);
    chk("t5_full_after_ign", tx_full, 1);
    spi_cs = 1'b0;
    repeat (3) @(negedge clk);
    tx_din = 8'h55;
    tx_wr  = 1'b1;
    @(negedge clk);
    tx_wr  = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_full_after_load", tx_full, 1);
    xfer(8'hA0, 8, 1'b0, mi);
    chk("t5_miso0", mi, 8'h11);
    xfer(8'hA1, 8, 1'b0, mi);
    chk("t5_miso1", mi, 8'h22);
    xfer(8'hA2, 8, 1'b0, mi);
    chk("t5_miso2", mi, 8'h33);
    xfer(8'hA3, 8, 1'b0, mi);
    chk("t5_miso3", mi, 8'h44);
    xfer(8'hA4, 8, 1'b0, mi);
    chk("t5_miso4", mi, 8'h55);
    cs_end();
    chk("t5_full_drained", tx_full, 0);
    chk("t5_underrun", tx_underrun, 0);
    pop_rx("t5_rx0", 8'hA0);
    repeat (3) begin
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
    end
    pulse_clr();

    // Reset in the middle of a byte
    abort_base = abort_cnt;
    push_tx(8'h77);
    cs_start();
    xfer(8'h5A, 4, 1'b0, mi);
    Rst = 1'b1;
    @(negedge clk);
    Rst = 1'b0;
    chk("t6_rst_miso", spi_miso, 1);
    chk("t6_rst_oe", spi_miso_oe, 0);
    chk("t6_rst_tx_full", tx_full, 0);
    chk("t6_rst_rx_avail", rx_data_avail, 0);
    chk("t6_rst_rx_dout", rx_dout, 8'h00);
    chk("t6_rst_flags", {tx_underrun, rx_overflow, frame_abort}, 0);
    cs_end();
    chk("t6_no_abort", abort_cnt - abort_base, 0);
    chk("t6_idle_oe", spi_miso_oe, 0);
    push_tx(8'hC3);
    cs_start();
    xfer(8'h5A, 8, 1'b0, mi);
    cs_end();
    chk("t6_miso", mi, 8'hC3);
    chk("t6_underrun", tx_underrun, 0);
    pop_rx("t6_rx", 8'h5A);
    chk("t6_rx_empty", rx_data_avail, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
